pipe_buf_stage: RTL and testbench
=================================

PIPE_BUF_STAGE -- requirements
Module: pipe_buf_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits (legal 1..512).
REQ-002 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer, 0 = single register.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage accepts a beat this cycle.
REQ-009 in_data  input  WIDTH  upstream payload (packed stage struct).
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts a beat this cycle.
REQ-012 out_data  output  WIDTH  downstream payload.
REQ-013 stall  input  1  hazard hold: freezes contents, blocks accept and release.
REQ-014 flush  input  1  branch/jump squash: discards all held and presented beats.
REQ-015 occupancy  output  2  number of held beats (0..2; max 1 when SKID=0).
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with stall=1.

Function
REQ-017 Accept occurs when in_valid & in_ready & !flush; release occurs when out_valid & out_ready & !stall & !flush.
REQ-018 When stall=1, in_ready SHALL be 0 and out_valid SHALL be 0; held contents and occupancy SHALL be unchanged.
REQ-019 When flush=1, the next state SHALL be empty with all payload registers zero, regardless of stall, in_valid or out_ready; the presented beat SHALL be discarded.
REQ-020 flush SHALL take priority over stall; in_ready MAY be 1 during flush but no beat is stored.
REQ-021 out_data SHALL equal the oldest held beat when out_valid=1 and all-zeros (bubble/NOP) otherwise.
REQ-022 Beats SHALL leave in acceptance order; no beat duplicated or lost except by flush.
REQ-023 Latency: an accepted beat into an empty stage SHALL appear on out_valid/out_data the next cycle (one-cycle latency, both modes).
REQ-024 SKID=0: in_ready = !stall & (occupancy==0 | out_ready); accept and release in the same cycle SHALL replace the register (occupancy stays 1).
REQ-025 SKID=1: in_ready SHALL be a registered signal equal to (occupancy<2), masked only by stall; no combinational path from out_ready to in_ready.
REQ-026 SKID=1, main full, out_ready=0, accept: beat SHALL go to skid entry, occupancy 2, in_ready 0 next cycle.
REQ-027 SKID=1, occupancy 2, release: skid beat SHALL move to main, occupancy 1, in_ready 1 next cycle.
REQ-028 SKID=1, occupancy 1, simultaneous accept and release: new beat SHALL load main, occupancy stays 1.
REQ-029 stall_cnt SHALL increment by 1 each cycle stall=1, saturate at 2^CNT_W-1, and be unaffected by flush.

Reset
REQ-030 On reset_n=0, asynchronously: occupancy 0, out_valid 0, out_data all-zeros, payload registers zero, stall_cnt 0.
REQ-031 During reset in_ready SHALL be 0; after deassertion in_ready SHALL be 1 from the first clock edge (both modes).
REQ-032 Reset mid-transfer SHALL discard all held beats; no beat SHALL emerge after reset that was accepted before it.

Verification
REQ-033 SKID=1, out_ready=1, beats 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, occupancy stays 1.
REQ-034 SKID=1, out_ready=0, beats 0xA,0xB -> occupancy 2, in_ready 0; raise out_ready -> 0xA then 0xB, in_ready 1 after first release.
REQ-035 Occupancy 2, flush=1 with in_valid=1 data 0xC -> next cycle occupancy 0, out_valid 0, out_data 0; 0xC never appears.
REQ-036 Occupancy 1 (0x5), stall=1 for 3 cycles with out_ready=1 -> out_valid 0, 0x5 retained, stall_cnt=3; stall low -> 0x5 released.
REQ-037 CNT_W=4, stall held 20 cycles -> stall_cnt saturates at 15.
REQ-038 SKID=0, out_ready toggling 1,0,1 with continuous beats -> in_ready follows out_ready combinationally while full, order preserved; reset_n pulse mid-stream -> out_valid 0 immediately, stale beats never emitted.

Source files
------------

// File: rtl/pipe_buf_stage.sv
// Pipeline buffer stage with optional two-entry skid buffer, stall/flush control
// and a saturating stall-cycle counter.
module pipe_buf_stage #(
   parameter int WIDTH = 64,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             stall,
   input  logic             flush,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [1:0]       occ_q, occ_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             rdy_q, rdy_d;
   logic             acc, rel;

   // rdy_q holds in_ready low through reset; in skid mode it is the registered occupancy<2
   always_comb begin
      out_valid = (occ_q != 2'd0) && !stall;
      out_data  = out_valid ? main_q : '0;
      if (SKID != 0)
         in_ready = rdy_q && !stall;
      else
         in_ready = rdy_q && !stall && ((occ_q == 2'd0) || out_ready);

      acc = in_valid && in_ready && !flush;
      rel = out_valid && out_ready && !flush;

      occ_d  = occ_q;
      main_d = main_q;
      skid_d = skid_q;

      if (flush) begin
         occ_d  = 2'd0;
         main_d = '0;
         skid_d = '0;
      end else if (occ_q == 2'd2) begin
         if (rel) begin
            main_d = skid_q;
            skid_d = '0;
            occ_d  = 2'd1;
         end
      end else if (acc && ((occ_q == 2'd0) || rel)) begin
         main_d = in_data;
         occ_d  = 2'd1;
      end else if (acc && (SKID != 0)) begin
         skid_d = in_data;
         occ_d  = 2'd2;
      end else if (rel) begin
         occ_d = 2'd0;
      end

      rdy_d = (SKID != 0) ? (occ_d != 2'd2) : 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_q  <= 2'd0;
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b0;
      end else begin
         occ_q  <= occ_d;
         main_q <= main_d;
         skid_q <= skid_d;
         rdy_q  <= rdy_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Bench for pipe_buf_stage: skid-mode vector table with scoreboard, counter
// saturation, and a register-mode stream with a mid-stream reset.
module tb_pipe_buf_stage;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid, out_ready, stall, flush;
   logic [7:0] in_data;

   logic       ir1, ov1;
   logic [7:0] od1;
   logic [1:0] occ1;
   logic [3:0] cnt1;

   logic        ir0, ov0;
   logic [7:0]  od0;
   logic [1:0]  occ0;
   logic [15:0] cnt0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_buf_stage #(.WIDTH(8), .SKID(1), .CNT_W(4)) u_skid (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
      .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .stall(stall), .flush(flush), .occupancy(occ1), .stall_cnt(cnt1));

   pipe_buf_stage #(.WIDTH(8), .SKID(0), .CNT_W(16)) u_reg (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir0),
      .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
      .stall(stall), .flush(flush), .occupancy(occ0), .stall_cnt(cnt0));

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy, st, fl;
      logic       e_ir, e_ov;
      logic [7:0] e_od;
      logic [1:0] e_occ;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb1[$];
   logic [7:0] sb0[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic iv, logic [7:0] d, logic o, logic s, logic f,
                               logic eir, logic eov, logic [7:0] eod,
                               logic [1:0] eocc, logic [3:0] ecnt);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = o; v.st = s; v.fl = f;
      v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_occ = eocc; v.e_cnt = ecnt;
      return v;
   endfunction

   initial begin
      //              iv  d      or st fl  ir ov od     occ cnt
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,  1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 8'h11, 1, 0, 0,  1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 8'h22, 1, 0, 0,  1, 1, 8'h11, 1, 0));
      vecs.push_back(mk(1, 8'h33, 1, 0, 0,  1, 1, 8'h22, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,  1, 1, 8'h33, 1, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0,  1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 8'h0A, 0, 0, 0,  1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 8'h0B, 0, 0, 0,  1, 1, 8'h0A, 1, 0));
      vecs.push_back(mk(1, 8'h0C, 0, 0, 0,  0, 1, 8'h0A, 2, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,  0, 1, 8'h0A, 2, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,  1, 1, 8'h0B, 1, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0,  1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 8'h01, 0, 0, 0,  1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 8'h02, 0, 0, 0,  1, 1, 8'h01, 1, 0));
      vecs.push_back(mk(1, 8'h0C, 1, 0, 1,  0, 1, 8'h01, 2, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,  1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 8'h05, 1, 0, 0,  1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 1, 0,  0, 0, 8'h00, 1, 0));
      vecs.push_back(mk(1, 8'h0D, 1, 1, 0,  0, 0, 8'h00, 1, 1));
      vecs.push_back(mk(0, 8'h00, 1, 1, 0,  0, 0, 8'h00, 1, 2));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,  1, 1, 8'h05, 1, 3));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,  1, 0, 8'h00, 0, 3));
      vecs.push_back(mk(1, 8'h07, 0, 0, 0,  1, 0, 8'h00, 0, 3));
      vecs.push_back(mk(1, 8'h08, 1, 1, 1,  0, 0, 8'h00, 1, 3));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,  1, 0, 8'h00, 0, 4));

      reset_n = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready_skid", ir1, 0);
      chk("rst_in_ready_reg", ir0, 0);
      chk("rst_out_valid", ov1, 0);
      chk("rst_out_data", od1, 0);
      chk("rst_occ", occ1, 0);
      chk("rst_cnt", cnt1, 0);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         logic exp_acc, exp_rel;
         @(negedge clk);
         in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
         stall = vecs[i].st; flush = vecs[i].fl;
         #1;
         chk($sformatf("v%0d_in_ready", i), ir1, vecs[i].e_ir);
         chk($sformatf("v%0d_out_valid", i), ov1, vecs[i].e_ov);
         chk($sformatf("v%0d_out_data", i), od1, vecs[i].e_od);
         chk($sformatf("v%0d_occ", i), occ1, vecs[i].e_occ);
         chk($sformatf("v%0d_cnt", i), cnt1, vecs[i].e_cnt);
         exp_acc = vecs[i].iv && vecs[i].e_ir && !vecs[i].fl;
         exp_rel = vecs[i].e_ov && vecs[i].ordy && !vecs[i].fl;
         if (exp_rel) begin
            if (sb1.size() == 0) chk($sformatf("v%0d_sb_underflow", i), 1, 0);
            else chk($sformatf("v%0d_sb_order", i), od1, sb1.pop_front());
         end
         if (vecs[i].fl) sb1.delete();
         if (exp_acc) sb1.push_back(vecs[i].d);
      end
      chk("sb_skid_empty", sb1.size(), 0);

      // counter saturation, flush pulses must not disturb it
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rst2_cnt", cnt1, 0);
      chk("rst2_cnt_reg", cnt0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 10) begin
            #1;
            chk("cnt_mid", cnt1, 10);
         end
         stall = 1'b1;
         flush = (i % 5 == 0);
      end
      @(negedge clk);
      stall = 1'b0; flush = 1'b0;
      #1;
      chk("cnt_saturated", cnt1, 15);
      chk("cnt_wide_20", cnt0, 20);

      // register mode: continuous beats with toggling out_ready
      begin
         logic       m_occ;
         logic       pat[9] = '{1, 1, 0, 0, 1, 0, 1, 1, 1};
         m_occ = 1'b0;
         for (int i = 0; i < 9; i++) begin
            logic e_ir, e_acc, e_rel;
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h40 + 8'(i); out_ready = pat[i];
            #1;
            e_ir  = !m_occ || pat[i];
            e_acc = e_ir;
            e_rel = m_occ && pat[i];
            chk($sformatf("r%0d_in_ready", i), ir0, e_ir);
            chk($sformatf("r%0d_out_valid", i), ov0, m_occ);
            chk($sformatf("r%0d_occ", i), occ0, {1'b0, m_occ});
            if (e_rel) begin
               if (sb0.size() == 0) chk($sformatf("r%0d_sb_underflow", i), 1, 0);
               else chk($sformatf("r%0d_sb_order", i), od0, sb0.pop_front());
            end
            if (e_acc) sb0.push_back(in_data);
            m_occ = e_acc ? 1'b1 : (e_rel ? 1'b0 : m_occ);
         end
         chk("r_sb_depth", sb0.size(), m_occ);
      end

      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
      #1;
      chk("r_full_before_reset", ov0, 1);
      reset_n = 1'b0;
      #1;
      chk("r_rst_out_valid", ov0, 0);
      chk("r_rst_out_data", od0, 0);
      chk("r_rst_occ", occ0, 0);
      chk("r_rst_in_ready", ir0, 0);
      chk("s_rst_out_valid", ov1, 0);
      @(negedge clk);
      reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      sb0.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("r_post_rst_ov%0d", i), ov0, 0);
         chk($sformatf("r_post_rst_ir%0d", i), ir0, 1);
      end
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h99;
      #1;
      chk("r_new_beat_ready", ir0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("r_new_beat_valid", ov0, 1);
      chk("r_new_beat_data", od0, 8'h99);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
